ram_burst_reader: RTL and testbench
===================================

// Module: ram_burst_reader
// PURPOSE
//   Read-side burst engine for the team's dual-port RAM: on a start command it issues
//   LEN sequential reads from START_ADDR on the RAM read port and presents the words as a
//   valid/ready stream. Absorbs the RAM's 1-cycle registered read latency. Sustains 1 word/clk
//   under continuous ready. Sits between the RAM read port and any downstream consumer.
// PARAMETERS
//   DATA_WIDTH  8  width of RAM word / stream data
//   ADDR_WIDTH  5  RAM address width; RAM depth = 2**ADDR_WIDTH
// PORTS
//   clk_i          in   1           single clock, also drives the RAM read clock
//   rst_i          in   1           synchronous, active-high reset
//   start_i        in   1           burst request; sampled only when busy_o=0
//   start_addr_i   in   ADDR_WIDTH  first RAM address of burst
//   len_m1_i       in   ADDR_WIDTH  burst length minus 1 (0 -> 1 word, all-ones -> full RAM)
//   busy_o         out  1           burst in progress
//   done_o         out  1           1-clk pulse on the edge after the last word's handshake
//   ram_rd_o       out  1           RAM read enable (to RAM rd_i)
//   ram_rd_addr_o  out  ADDR_WIDTH  RAM read address
//   ram_rd_data_i  in   DATA_WIDTH  RAM read data, valid 1 clk after ram_rd_o
//   data_o         out  DATA_WIDTH  stream data
//   valid_o        out  1           stream valid
//   ready_i        in   1           stream ready
// BEHAVIOUR
//   - Reset: busy_o=0, done_o=0, valid_o=0, ram_rd_o=0, ram_rd_addr_o=0, data_o=0, FIFO empty,
//     state IDLE. Reset mid-burst aborts: in-flight RAM word discarded, buffered words dropped, no done_o.
//   - FSM: IDLE -> READ on start_i (latch addr, issue counter=len_m1_i+1, pop counter likewise);
//     READ -> DRAIN when last read issued; DRAIN -> IDLE on last handshake (done_o=1 next clk).
//     If the only/last read issues, READ goes straight to DRAIN same edge.
//   - start_i while busy_o=1 is ignored (no queuing). busy_o falls on the same edge done_o rises;
//     a start_i in the done_o cycle is accepted.
//   - Issue rule (READ only): ram_rd_o = (fifo_cnt + inflight - pop) < 2, where
//     pop = valid_o & ready_i, inflight = ram_rd_o registered. ram_rd_o/ram_rd_addr_o combinational
//     from registers; address increments after each issue, wraps modulo 2**ADDR_WIDTH.
//   - Capture: registered inflight flag pushes ram_rd_data_i into 2-entry FIFO on next edge.
//   - Stream: valid_o = FIFO non-empty; data_o = FIFO head; data_o/valid_o held stable while
//     valid_o & !ready_i (AXI-style rule: valid never retracts without handshake).
//   - Latency: start accepted at edge E0 -> ram_rd_o high in cycle E0..E1 -> valid_o high after E2.
//   - Simultaneous push and pop in FIFO: count unchanged, order preserved. FIFO never overflows
//     (guaranteed by issue rule; bench asserts it).
//   - Counters width ADDR_WIDTH+1 so full-RAM burst (2**ADDR_WIDTH words) is representable.
// CONFIGURATION
//   RAM_BURST_READER_LAST_EN defined: extra port last_o (out, 1) = 1 with valid_o on the final
//     word of the burst, 0 otherwise, reset 0, stored alongside data in FIFO.
//   Not defined: no last_o port, no extra FIFO bit; all other behaviour identical.
// STRUCTURE
//   ram_burst_reader_pkg: typedef enum logic [1:0] {IDLE, READ, DRAIN} rbr_state_t;
//     localparam FIFO_DEPTH = 2.
//   Sub-module ram_rd_skid_fifo: 2-entry sync FIFO (push, pop, data, empty, count), WIDTH param
//     covers data plus optional last bit.
// TESTING
//   - RAM preloaded with addr value; start addr=3, len_m1=4, ready=1 -> data 3,4,5,6,7 on 5
//     consecutive cycles, first valid 2 clks after start, done_o one pulse, busy_o drops.
//   - ADDR_WIDTH=5, start addr=30, len_m1=3 -> data 30,31,0,1 (wrap).
//   - len_m1=31 with ready toggling randomly -> all 32 words in order, no loss/duplication,
//     data_o stable under stall, FIFO count never exceeds 2.
//   - ready_i=0 for 10 clks after start, len_m1=7 -> ram_rd_o stops after 2 issues, resumes
//     on ready; output 8 correct words.
//   - rst_i asserted mid-burst (after 3 words) -> next clk all outputs at reset values; new burst
//     addr=0 len_m1=1 returns 0,1 only; start_i while busy ignored.
//   - RAM_BURST_READER_LAST_EN: len_m1=0 -> single word with last_o=1; len_m1=2 -> last_o only on 3rd.

Source files
------------

// File: rtl/ram_burst_reader_pkg.sv
// Shared types for the RAM burst reader: FSM state encoding and skid FIFO depth.
package ram_burst_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rbr_state_t;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/ram_rd_skid_fifo.sv
// Two-entry synchronous FIFO that absorbs the RAM read latency between issue and stream.
// Storage is cleared on reset so the stream data output reads zero out of reset.
module ram_rd_skid_fifo
  import ram_burst_reader_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;

  // Pointer/count bookkeeping and storage writes; push+pop together keeps the count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/ram_burst_reader.sv
// Read-side burst engine: issues sequential RAM reads and streams the words out
// over valid/ready at up to one word per clock.
// Optional feature macro: RAM_BURST_READER_LAST_EN adds last_o, flagging the final word.
module ram_burst_reader
  import ram_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  input  logic [ADDR_WIDTH-1:0] len_m1_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  ram_rd_o,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_rd_data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
`ifdef RAM_BURST_READER_LAST_EN
  output logic                  last_o,
`endif
  input  logic                  ready_i
);

  // One extra bit so a full-RAM burst (2**ADDR_WIDTH words) fits in the counters.
  localparam int CW = ADDR_WIDTH + 1;
`ifdef RAM_BURST_READER_LAST_EN
  localparam int FW = DATA_WIDTH + 1;
`else
  localparam int FW = DATA_WIDTH;
`endif

  rbr_state_t            state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CW-1:0]         issue_cnt_q;
  logic [CW-1:0]         pop_cnt_q;
  logic [CW-1:0]         len_ext;
  logic                  done_q;
  logic                  inflight_p1;
  logic                  pop;
  logic [2:0]            occ;
  logic                  fifo_empty;
  logic [1:0]            fifo_cnt;
  logic [FW-1:0]         fifo_din;
  logic [FW-1:0]         fifo_dout;

  assign len_ext = {1'b0, len_m1_i} + CW'(1);
  assign pop     = valid_o & ready_i;

  // Words already buffered or on their way, net of the word leaving this cycle;
  // keeping this below two is what guarantees the FIFO can never overflow.
  assign occ      = {1'b0, fifo_cnt} + {2'b00, inflight_p1} - {2'b00, pop};
  assign ram_rd_o = (state_q == READ) && (occ < 3'd2);
  assign ram_rd_addr_o = addr_q;

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;

  // Burst control FSM: latch the command, count issues and handshakes, pulse done.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      pop_cnt_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (pop) pop_cnt_q <= pop_cnt_q - CW'(1);
      case (state_q)
        IDLE: begin
          if (start_i) begin
            addr_q      <= start_addr_i;
            issue_cnt_q <= len_ext;
            pop_cnt_q   <= len_ext;
            state_q     <= READ;
          end
        end
        READ: begin
          if (ram_rd_o) begin
            addr_q      <= addr_q + ADDR_WIDTH'(1);
            issue_cnt_q <= issue_cnt_q - CW'(1);
            if (issue_cnt_q == CW'(1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && (pop_cnt_q == CW'(1))) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef RAM_BURST_READER_LAST_EN
  logic inflight_last_p1;

  // Stage p1: remember which reads are in flight, and whether each is the burst's final word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_p1      <= 1'b0;
      inflight_last_p1 <= 1'b0;
    end else begin
      inflight_p1      <= ram_rd_o;
      inflight_last_p1 <= ram_rd_o && (issue_cnt_q == CW'(1));
    end
  end

  assign fifo_din = {inflight_last_p1, ram_rd_data_i};
  assign last_o   = valid_o & fifo_dout[DATA_WIDTH];
`else
  // Stage p1: remember which cycles have a RAM word arriving.
  always_ff @(posedge clk_i) begin
    if (rst_i) inflight_p1 <= 1'b0;
    else       inflight_p1 <= ram_rd_o;
  end

  assign fifo_din = ram_rd_data_i;
`endif

  // Stage p2: returned words are buffered and presented on the stream.
  ram_rd_skid_fifo #(
    .WIDTH (FW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (inflight_p1),
    .pop_i   (pop),
    .data_i  (fifo_din),
    .data_o  (fifo_dout),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign valid_o = ~fifo_empty;
  assign data_o  = fifo_dout[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader with a registered-read RAM model and a scoreboard.
module tb_ram_burst_reader;

  localparam int DW = 8;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] len_m1;
  logic          busy, done, ram_rd, valid, ready;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_q;
  logic [DW-1:0] data;
`ifdef RAM_BURST_READER_LAST_EN
  logic          last;
`endif

  always #5 clk = ~clk;

  ram_burst_reader #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) u_dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .start_addr_i  (start_addr),
    .len_m1_i      (len_m1),
    .busy_o        (busy),
    .done_o        (done),
    .ram_rd_o      (ram_rd),
    .ram_rd_addr_o (ram_addr),
    .ram_rd_data_i (ram_q),
    .data_o        (data),
    .valid_o       (valid),
`ifdef RAM_BURST_READER_LAST_EN
    .last_o        (last),
`endif
    .ready_i       (ready)
  );

  // RAM model: preloaded with each address as its own value, 1-cycle registered read.
  logic [DW-1:0] ram_mem [2**AW];
  initial for (int i = 0; i < 2**AW; i++) ram_mem[i] = DW'(i);
  initial ram_q = '0;
  always @(posedge clk) if (ram_rd) ram_q <= ram_mem[ram_addr];

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_cmp = 0;
  int n_err = 0;
  int hs_cnt = 0, done_cnt = 0, rd_cnt = 0, vld_cyc = 0;
  logic          pv = 1'b0, pr = 1'b0, prst = 1'b1;
  logic [DW-1:0] pd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard pops on handshakes, stall stability, FIFO bound, event counters.
  always @(negedge clk) begin
    if (!rst) begin
      chk("fifo_cnt_le2", 32'(u_dut.u_fifo.count_o <= 2'd2), 32'd1);
      if (pv && !pr && !prst) begin
        chk("stall_valid", 32'(valid), 32'd1);
        chk("stall_data", 32'(data), 32'(pd));
      end
      if (valid && ready) begin
        hs_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_word", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("data", 32'(data), 32'(mon_e.d));
`ifdef RAM_BURST_READER_LAST_EN
          chk("last", 32'(last), 32'(mon_e.l));
`endif
        end
      end
`ifdef RAM_BURST_READER_LAST_EN
      if (!valid) chk("last_idle", 32'(last), 32'd0);
`endif
      if (done)   done_cnt++;
      if (ram_rd) rd_cnt++;
      if (valid)  vld_cyc++;
    end
    pv   = valid;
    pr   = ready;
    pd   = data;
    prst = rst;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    hs_cnt = 0; done_cnt = 0; rd_cnt = 0; vld_cyc = 0;
  endtask

  task automatic push_exp(input int a, input int l);
    exp_t e;
    for (int k = 0; k <= l; k++) begin
      e.d = DW'((a + k) % (2**AW));
      e.l = (k == l);
      sb.push_back(e);
    end
  endtask

  task automatic start_burst(input int a, input int l);
    push_exp(a, l);
    start      = 1'b1;
    start_addr = AW'(a);
    len_m1     = AW'(l);
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max, input bit rnd);
    int i;
    i = 0;
    while (busy && i < max) begin
      if (rnd) ready = 1'($urandom_range(0, 1));
      step();
      i++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
    ready = 1'b1;
    step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_addr = '0; len_m1 = '0; ready = 1'b1;
    step(); step(); step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_ram_rd", 32'(ram_rd), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    rst = 1'b0;
    step();

    // Basic burst: addr 3, five words, continuous ready, check latency.
    clr_counts();
    start_burst(3, 4);
    chk("a_busy", 32'(busy), 32'd1);
    chk("a_rd_first", 32'(ram_rd), 32'd1);
    chk("a_addr_first", 32'(ram_addr), 32'd3);
    step();
    chk("a_valid_e1", 32'(valid), 32'd0);
    step();
    chk("a_valid_e2", 32'(valid), 32'd1);
    chk("a_data_e2", 32'(data), 32'd3);
    wait_idle(30, 1'b0);
    chk("a_words", 32'(hs_cnt), 32'd5);
    chk("a_consecutive", 32'(vld_cyc), 32'd5);
    chk("a_done_pulses", 32'(done_cnt), 32'd1);
    chk("a_sb_empty", 32'(sb.size()), 32'd0);

    // Address wrap: 30,31,0,1.
    clr_counts();
    start_burst(30, 3);
    wait_idle(30, 1'b0);
    chk("wrap_words", 32'(hs_cnt), 32'd4);
    chk("wrap_done", 32'(done_cnt), 32'd1);
    chk("wrap_sb_empty", 32'(sb.size()), 32'd0);

    // Full RAM burst with random backpressure.
    clr_counts();
    start_burst(0, 31);
    wait_idle(400, 1'b1);
    chk("full_words", 32'(hs_cnt), 32'd32);
    chk("full_done", 32'(done_cnt), 32'd1);
    chk("full_sb_empty", 32'(sb.size()), 32'd0);

    // Held-off consumer: only two reads may be issued before ready returns.
    ready = 1'b0;
    clr_counts();
    start_burst(10, 7);
    for (int i = 0; i < 9; i++) step();
    chk("stall_issues", 32'(rd_cnt), 32'd2);
    chk("stall_head", 32'(data), 32'd10);
    ready = 1'b1;
    wait_idle(40, 1'b0);
    chk("stall_words", 32'(hs_cnt), 32'd8);
    chk("stall_sb_empty", 32'(sb.size()), 32'd0);

    // Reset mid-burst after three words.
    clr_counts();
    start_burst(8, 9);
    for (int i = 0; i < 40 && hs_cnt < 3; i++) step();
    chk("mid_reach3", 32'(hs_cnt), 32'd3);
    rst = 1'b1; ready = 1'b0;
    step();
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_valid", 32'(valid), 32'd0);
    chk("mid_ram_rd", 32'(ram_rd), 32'd0);
    chk("mid_addr", 32'(ram_addr), 32'd0);
    chk("mid_data", 32'(data), 32'd0);
    chk("mid_no_done", 32'(done_cnt), 32'd0);
    rst = 1'b0; ready = 1'b1;
    sb.delete();
    step();

    // New burst after reset; a second start while busy must be ignored.
    clr_counts();
    start_burst(0, 1);
    start = 1'b1; start_addr = AW'(20); len_m1 = AW'(5);
    step();
    start = 1'b0;
    wait_idle(30, 1'b0);
    step(); step(); step();
    chk("post_words", 32'(hs_cnt), 32'd2);
    chk("post_done", 32'(done_cnt), 32'd1);
    chk("post_not_queued", 32'(busy), 32'd0);
    chk("post_sb_empty", 32'(sb.size()), 32'd0);

    // Single-word and three-word bursts (last flag checked when enabled).
    clr_counts();
    start_burst(7, 0);
    wait_idle(20, 1'b0);
    chk("one_words", 32'(hs_cnt), 32'd1);
    clr_counts();
    start_burst(12, 2);
    wait_idle(20, 1'b0);
    chk("three_words", 32'(hs_cnt), 32'd3);
    chk("three_sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1);
  end

endmodule
